mem_port_arbiter: RTL and testbench

Arbitrates one shared Wishbone-style memory port between instruction fetch (IF) and data access (MEM stage). It sequences one bus transaction at a time, returns read data with a one-cycle ack pulse, and drives stall requests into ctrl until each requester is served. MEM has priority over IF, with a starvation guard, an IF cancel on branch flush, and a bus timeout.

---
 rtl/mem_port_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one Wishbone-style memory port between the
// instruction-fetch requester and the MEM-stage data requester. MEM wins
// ties unless IF has already been passed over IF_STARVE_MAX times in a row.
// Transactions run one at a time: IDLE -> *_BUSY -> DONE -> IDLE. A fetch can
// be cancelled by a branch flush, and a silent slave is aborted after TIMEOUT
// bus cycles with bus_err_o raised alongside the ack.
module mem_port_arbiter #(
  parameter int IF_STARVE_MAX = 4,
  parameter int TIMEOUT       = 16
) (
  input  logic        clk,
  input  logic        rst,
  // instruction fetch requester
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_flush_i,
  output logic [31:0] if_rdata_o,
  output logic        if_ack_o,
  // data requester
  input  logic        mem_req_i,
  input  logic        mem_we_i,
  input  logic [3:0]  mem_sel_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_wdata_i,
  output logic [31:0] mem_rdata_o,
  output logic        mem_ack_o,
  // shared bus master port
  output logic        bus_cyc_o,
  output logic        bus_stb_o,
  output logic        bus_we_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_addr_o,
  output logic [31:0] bus_wdata_o,
  input  logic [31:0] bus_rdata_i,
  input  logic        bus_ack_i,
  output logic        bus_err_o,
  // stall requests towards ctrl
  output logic        stallreq_if_o,
  output logic        stallreq_mem_o
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_IF_BUSY  = 2'd1,
    S_MEM_BUSY = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  // Counter widths: the starve counter must hold IF_STARVE_MAX itself,
  // the timeout counter only needs to reach TIMEOUT-1.
  localparam int SW = (IF_STARVE_MAX < 1) ? 1 : $clog2(IF_STARVE_MAX + 1);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [SW-1:0] STARVE_MAX_V = SW'(IF_STARVE_MAX);
  localparam logic [TW-1:0] TMO_LAST     = TW'(TIMEOUT - 1);

  state_t        r_state;
  logic [SW-1:0] r_starve;
  logic [TW-1:0] r_tmo;
  logic          r_bus_cyc;
  logic          r_bus_stb;
  logic          r_bus_we;
  logic [3:0]    r_bus_sel;
  logic [31:0]   r_bus_addr;
  logic [31:0]   r_bus_wdata;
  logic          r_bus_err;
  logic          r_if_ack;
  logic          r_mem_ack;
  logic [31:0]   r_if_rdata;
  logic [31:0]   r_mem_rdata;

  logic          w_if_starved;
  logic          w_grant_mem;
  logic          w_timeout;
  logic [31:0]   w_done_data;

  // IF has waited long enough: a pending fetch now beats a pending MEM access.
  assign w_if_starved = if_req_i && (r_starve == STARVE_MAX_V);
  assign w_grant_mem  = mem_req_i && !w_if_starved;
  assign w_timeout    = (r_tmo == TMO_LAST);
  // An aborted transaction returns zero rather than whatever floats on the bus.
  assign w_done_data  = bus_ack_i ? bus_rdata_i : 32'h0;

  // Arbitration FSM with all bus-facing and requester-facing outputs registered.
  // NOTE: every register here is updated with <= so that all of them see the
  // pre-edge values of each other; mixing in = would make the result depend on
  // statement order within the block.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_starve    <= '0;
      r_tmo       <= '0;
      r_bus_cyc   <= 1'b0;
      r_bus_stb   <= 1'b0;
      r_bus_we    <= 1'b0;
      r_bus_sel   <= 4'h0;
      r_bus_addr  <= 32'h0;
      r_bus_wdata <= 32'h0;
      r_bus_err   <= 1'b0;
      r_if_ack    <= 1'b0;
      r_mem_ack   <= 1'b0;
      r_if_rdata  <= 32'h0;
      r_mem_rdata <= 32'h0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant_mem) begin
            r_state     <= S_MEM_BUSY;
            r_bus_cyc   <= 1'b1;
            r_bus_stb   <= 1'b1;
            r_bus_we    <= mem_we_i;
            r_bus_sel   <= mem_sel_i;
            r_bus_addr  <= mem_addr_i;
            r_bus_wdata <= mem_wdata_i;
            r_tmo       <= '0;
            if (if_req_i && (r_starve != STARVE_MAX_V)) begin
              r_starve <= r_starve + 1'b1;
            end
          end else if (if_req_i) begin
            r_state     <= S_IF_BUSY;
            r_bus_cyc   <= 1'b1;
            r_bus_stb   <= 1'b1;
            r_bus_we    <= 1'b0;
            r_bus_sel   <= 4'hF;
            r_bus_addr  <= if_addr_i;
            r_tmo       <= '0;
            r_starve    <= '0;
          end
        end

        S_IF_BUSY, S_MEM_BUSY: begin
          if ((r_state == S_IF_BUSY) && if_flush_i) begin
            // Branch flush cancels the fetch outright, even against a same-cycle ack.
            r_state   <= S_IDLE;
            r_bus_cyc <= 1'b0;
            r_bus_stb <= 1'b0;
          end else if (bus_ack_i || w_timeout) begin
            r_state   <= S_DONE;
            r_bus_cyc <= 1'b0;
            r_bus_stb <= 1'b0;
            r_bus_err <= !bus_ack_i;
            if (r_state == S_IF_BUSY) begin
              r_if_ack   <= 1'b1;
              r_if_rdata <= w_done_data;
            end else begin
              r_mem_ack   <= 1'b1;
              r_mem_rdata <= w_done_data;
            end
          end else begin
            r_tmo <= r_tmo + 1'b1;
          end
        end

        S_DONE: begin
          // One-cycle ack window; no grant here so a still-high req is not served twice.
          r_state   <= S_IDLE;
          r_if_ack  <= 1'b0;
          r_mem_ack <= 1'b0;
          r_bus_err <= 1'b0;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus_cyc_o   = r_bus_cyc;
  assign bus_stb_o   = r_bus_stb;
  assign bus_we_o    = r_bus_we;
  assign bus_sel_o   = r_bus_sel;
  assign bus_addr_o  = r_bus_addr;
  assign bus_wdata_o = r_bus_wdata;
  assign bus_err_o   = r_bus_err;
  assign if_ack_o    = r_if_ack;
  assign mem_ack_o   = r_mem_ack;
  assign if_rdata_o  = r_if_rdata;
  assign mem_rdata_o = r_mem_rdata;

  // Stalls depend only on raw requests and registered acks: no path back through ctrl.
  assign stallreq_if_o  = if_req_i  & ~r_if_ack;
  assign stallreq_mem_o = mem_req_i & ~r_mem_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed scenarios followed by randomized traffic,
// every cycle compared against a transaction-level reference model that
// tracks bus ownership with edge-number arithmetic.
module tb_mem_port_arbiter;

  localparam int IF_STARVE_MAX = 4;
  localparam int TIMEOUT       = 16;
  localparam int NEVER         = 1000;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_flush_i;
  logic [31:0] if_rdata_o;
  logic        if_ack_o;
  logic        mem_req_i;
  logic        mem_we_i;
  logic [3:0]  mem_sel_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_wdata_i;
  logic [31:0] mem_rdata_o;
  logic        mem_ack_o;
  logic        bus_cyc_o;
  logic        bus_stb_o;
  logic        bus_we_o;
  logic [3:0]  bus_sel_o;
  logic [31:0] bus_addr_o;
  logic [31:0] bus_wdata_o;
  logic [31:0] bus_rdata_i;
  logic        bus_ack_i;
  logic        bus_err_o;
  logic        stallreq_if_o;
  logic        stallreq_mem_o;

  mem_port_arbiter #(
    .IF_STARVE_MAX(IF_STARVE_MAX),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .if_req_i      (if_req_i),
    .if_addr_i     (if_addr_i),
    .if_flush_i    (if_flush_i),
    .if_rdata_o    (if_rdata_o),
    .if_ack_o      (if_ack_o),
    .mem_req_i     (mem_req_i),
    .mem_we_i      (mem_we_i),
    .mem_sel_i     (mem_sel_i),
    .mem_addr_i    (mem_addr_i),
    .mem_wdata_i   (mem_wdata_i),
    .mem_rdata_o   (mem_rdata_o),
    .mem_ack_o     (mem_ack_o),
    .bus_cyc_o     (bus_cyc_o),
    .bus_stb_o     (bus_stb_o),
    .bus_we_o      (bus_we_o),
    .bus_sel_o     (bus_sel_o),
    .bus_addr_o    (bus_addr_o),
    .bus_wdata_o   (bus_wdata_o),
    .bus_rdata_i   (bus_rdata_i),
    .bus_ack_i     (bus_ack_i),
    .bus_err_o     (bus_err_o),
    .stallreq_if_o (stallreq_if_o),
    .stallreq_mem_o(stallreq_mem_o)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef enum int {OWN_NONE, OWN_IF, OWN_MEM} owner_e;

  bit          m_valid = 1'b0;
  owner_e      m_owner;
  int          edge_num = 0;
  int          m_grant_edge;
  int          m_earliest;
  int          m_starve;
  bit          m_after_rst;
  logic        m_we;
  logic [3:0]  m_sel;
  logic [31:0] m_addr, m_wdata;
  logic        m_if_ack, m_mem_ack, m_err;
  logic [31:0] m_if_rdata, m_mem_rdata;

  // Predict what the coming clock edge does, from the inputs now on the pins.
  task automatic model_edge();
    logic [31:0] data;
    edge_num++;
    m_if_ack  = 1'b0;
    m_mem_ack = 1'b0;
    m_err     = 1'b0;
    if (rst) begin
      m_valid     = 1'b1;
      m_owner     = OWN_NONE;
      m_earliest  = edge_num + 1;
      m_starve    = 0;
      m_after_rst = 1'b1;
      m_we = 1'b0; m_sel = 4'h0; m_addr = 32'h0; m_wdata = 32'h0;
      m_if_rdata = 32'h0; m_mem_rdata = 32'h0;
    end else if (m_owner == OWN_IF && if_flush_i) begin
      m_owner    = OWN_NONE;
      m_earliest = edge_num + 1;
    end else if (m_owner != OWN_NONE) begin
      if (bus_ack_i || (edge_num - m_grant_edge == TIMEOUT)) begin
        data = bus_ack_i ? bus_rdata_i : 32'h0;
        if (m_owner == OWN_IF) begin m_if_ack = 1'b1; m_if_rdata = data; end
        else begin m_mem_ack = 1'b1; m_mem_rdata = data; end
        m_err      = !bus_ack_i;
        m_owner    = OWN_NONE;
        m_earliest = edge_num + 2;
      end
    end else if (edge_num >= m_earliest) begin
      if (mem_req_i && !(if_req_i && m_starve == IF_STARVE_MAX)) begin
        m_owner = OWN_MEM;
        m_we = mem_we_i; m_sel = mem_sel_i; m_addr = mem_addr_i; m_wdata = mem_wdata_i;
        if (if_req_i && m_starve < IF_STARVE_MAX) m_starve++;
      end else if (if_req_i) begin
        m_owner = OWN_IF;
        m_we = 1'b0; m_sel = 4'hF; m_addr = if_addr_i;
        m_starve = 0;
      end
      if (m_owner != OWN_NONE) begin
        m_grant_edge = edge_num;
        m_after_rst  = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    logic busy;
    busy = (m_owner != OWN_NONE);
    check("bus_cyc", 32'(bus_cyc_o), 32'(busy));
    check("bus_stb", 32'(bus_stb_o), 32'(busy));
    if (busy) begin
      check("bus_we",   32'(bus_we_o),  32'(m_we));
      check("bus_sel",  32'(bus_sel_o), 32'(m_sel));
      check("bus_addr", bus_addr_o, m_addr);
      if (m_owner == OWN_MEM) check("bus_wdata", bus_wdata_o, m_wdata);
    end else if (m_after_rst) begin
      check("rst_we",    32'(bus_we_o),  32'h0);
      check("rst_sel",   32'(bus_sel_o), 32'h0);
      check("rst_addr",  bus_addr_o,     32'h0);
      check("rst_wdata", bus_wdata_o,    32'h0);
    end
    check("if_ack",    32'(if_ack_o),  32'(m_if_ack));
    check("mem_ack",   32'(mem_ack_o), 32'(m_mem_ack));
    check("bus_err",   32'(bus_err_o), 32'(m_err));
    check("if_rdata",  if_rdata_o,  m_if_rdata);
    check("mem_rdata", mem_rdata_o, m_mem_rdata);
    check("stall_if",  32'(stallreq_if_o),  32'(if_req_i & ~m_if_ack));
    check("stall_mem", 32'(stallreq_mem_o), 32'(mem_req_i & ~m_mem_ack));
    check("one_ack",   32'(if_ack_o & mem_ack_o), 32'h0);
  endtask

  // ---------------- stimulus agents ----------------
  bit          auto_mode = 1'b0;
  bit          if_rearm = 1'b0, mem_rearm = 1'b0;
  int          slv_fixed = 0;
  bit          slv_data_rand = 1'b1;
  logic [31:0] slv_data_fixed = 32'h0;
  bit          slv_force_ack = 1'b0;
  int          slv_cnt = 0, slv_target = 0;
  bit          seen_if_ack = 1'b0, seen_mem_ack = 1'b0;
  int          cyc_num = 0;
  int          n_if_acks, n_mem_acks, n_cyc_hi, n_err_ack;
  int          ack_who[$];
  int          ack_cyc[$];

  function automatic int pick_wait();
    int r;
    r = $urandom_range(0, 19);
    if (r < 8) return 0;
    if (r < 17) return $urandom_range(1, 6);
    return NEVER;
  endfunction

  task automatic drive_slave();
    bus_rdata_i = slv_data_rand ? $urandom : slv_data_fixed;
    if (bus_cyc_o === 1'b1) begin
      if (slv_cnt == 0) slv_target = (slv_fixed >= 0) ? slv_fixed : pick_wait();
      bus_ack_i = (slv_cnt == slv_target) || slv_force_ack;
      slv_cnt++;
    end else begin
      slv_cnt   = 0;
      bus_ack_i = slv_force_ack || (auto_mode && $urandom_range(0, 15) == 0);
    end
  endtask

  task automatic new_mem_attrs();
    mem_we_i    = $urandom_range(0, 1);
    mem_sel_i   = 4'($urandom_range(1, 15));
    mem_addr_i  = $urandom & 32'hFFFF_FFFC;
    mem_wdata_i = $urandom;
  endtask

  task automatic drive_reqs();
    if (auto_mode) begin
      if (seen_if_ack) begin
        if_req_i  = ($urandom_range(0, 2) != 0);
        if_addr_i = $urandom & 32'hFFFF_FFFC;
      end else if (!if_req_i && $urandom_range(0, 3) == 0) begin
        if_req_i  = 1'b1;
        if_addr_i = $urandom & 32'hFFFF_FFFC;
      end
      if_flush_i = if_req_i && ($urandom_range(0, 11) == 0);
      if (if_flush_i) if_addr_i = $urandom & 32'hFFFF_FFFC;
      if (seen_mem_ack) begin
        mem_req_i = ($urandom_range(0, 2) != 0);
        new_mem_attrs();
      end else if (!mem_req_i && $urandom_range(0, 1) == 0) begin
        mem_req_i = 1'b1;
        new_mem_attrs();
      end
      rst = ($urandom_range(0, 299) == 0);
    end else begin
      if (seen_if_ack) begin if_req_i = if_rearm; if_addr_i = if_addr_i + 32'd4; end
      if (seen_mem_ack) begin mem_req_i = mem_rearm; mem_addr_i = mem_addr_i + 32'd4; end
    end
    seen_if_ack  = 1'b0;
    seen_mem_ack = 1'b0;
  endtask

  // One clock cycle: drive just after posedge, check and predict at negedge.
  task automatic cycle();
    drive_reqs();
    drive_slave();
    @(negedge clk);
    if (m_valid) check_outputs();
    if (if_ack_o === 1'b1) begin
      seen_if_ack = 1'b1; n_if_acks++; ack_who.push_back(1); ack_cyc.push_back(cyc_num);
    end
    if (mem_ack_o === 1'b1) begin
      seen_mem_ack = 1'b1; n_mem_acks++; ack_who.push_back(2); ack_cyc.push_back(cyc_num);
      if (bus_err_o === 1'b1) n_err_ack++;
    end
    if (bus_cyc_o === 1'b1) n_cyc_hi++;
    model_edge();
    cyc_num++;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_counts();
    n_if_acks = 0; n_mem_acks = 0; n_cyc_hi = 0; n_err_ack = 0;
    ack_who.delete();
    ack_cyc.delete();
  endtask

  function automatic int ack_at(int idx);
    if (idx < ack_cyc.size()) return ack_cyc[idx];
    return -1000;
  endfunction

  function automatic int who_at(int idx);
    if (idx < ack_who.size()) return ack_who[idx];
    return 0;
  endfunction

  int s0;
  int mem_before, mem_between, if_seen;

  initial begin
    rst = 1'b1;
    if_req_i = 1'b0; if_addr_i = 32'h0; if_flush_i = 1'b0;
    mem_req_i = 1'b0; mem_we_i = 1'b0; mem_sel_i = 4'h0; mem_addr_i = 32'h0; mem_wdata_i = 32'h0;
    bus_rdata_i = 32'h0; bus_ack_i = 1'b0;
    clear_counts();
    cycle();
    cycle();
    rst = 1'b0;

    // Single IF read of 0x100, zero-wait slave.
    clear_counts();
    s0 = cyc_num;
    slv_fixed = 0; slv_data_rand = 1'b0; slv_data_fixed = 32'h3C01_0001;
    if_req_i = 1'b1; if_addr_i = 32'h100;
    repeat (5) cycle();
    check("s1_if_acks", n_if_acks, 1);
    check("s1_ack_cycle", ack_at(0) - s0, 2);
    check("s1_if_rdata", if_rdata_o, 32'h3C01_0001);
    check("s1_cyc_cycles", n_cyc_hi, 1);

    // Simultaneous IF and MEM read: MEM first, IF three cycles of ack later.
    clear_counts();
    slv_data_rand = 1'b1;
    if_req_i = 1'b1; if_addr_i = 32'h180;
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h300; mem_wdata_i = 32'h0;
    repeat (8) cycle();
    check("s2_first_mem", who_at(0), 2);
    check("s2_then_if", who_at(1), 1);
    check("s2_ack_gap", ack_at(1) - ack_at(0), 3);

    // Starvation guard: both held high, MEM back-to-back.
    clear_counts();
    if_rearm = 1'b1; mem_rearm = 1'b1;
    if_req_i = 1'b1; if_addr_i = 32'h1000;
    mem_req_i = 1'b1; mem_addr_i = 32'h2000;
    for (int i = 0; i < 200 && n_if_acks < 2; i++) cycle();
    mem_before = 0; mem_between = 0; if_seen = 0;
    foreach (ack_who[i]) begin
      if (ack_who[i] == 1) if_seen++;
      else if (if_seen == 0) mem_before++;
      else if (if_seen == 1) mem_between++;
    end
    check("s3_if_acks", n_if_acks, 2);
    check("s3_mem_before_if", mem_before, IF_STARVE_MAX);
    check("s3_mem_between_if", mem_between, IF_STARVE_MAX);
    if_rearm = 1'b0; mem_rearm = 1'b0;
    for (int i = 0; i < 200 && (if_req_i || mem_req_i); i++) cycle();
    check("s3_drained", 32'(if_req_i | mem_req_i), 32'h0);
    repeat (2) cycle();

    // MEM write with three wait states.
    clear_counts();
    s0 = cyc_num;
    slv_fixed = 3;
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'b0011;
    mem_addr_i = 32'h200; mem_wdata_i = 32'hDEAD_BEEF;
    repeat (8) cycle();
    check("s4_cyc_cycles", n_cyc_hi, 4);
    check("s4_mem_acks", n_mem_acks, 1);
    check("s4_ack_cycle", ack_at(0) - s0, 5);

    // Slave never acks: timeout abort.
    clear_counts();
    slv_fixed = NEVER;
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_sel_i = 4'hF; mem_addr_i = 32'h240;
    repeat (22) cycle();
    check("s5_cyc_cycles", n_cyc_hi, TIMEOUT);
    check("s5_err_with_ack", n_err_ack, 1);
    check("s5_mem_rdata", mem_rdata_o, 32'h0);

    // Flush in the second IF_BUSY cycle, with a colliding slave ack.
    clear_counts();
    s0 = cyc_num;
    slv_data_rand = 1'b0; slv_data_fixed = 32'h1234_5678;
    if_req_i = 1'b1; if_addr_i = 32'h400;
    cycle();
    cycle();
    if_flush_i = 1'b1; if_addr_i = 32'h800; slv_force_ack = 1'b1; slv_fixed = 0;
    cycle();
    if_flush_i = 1'b0; slv_force_ack = 1'b0;
    repeat (5) cycle();
    check("s6_if_acks", n_if_acks, 1);
    check("s6_ack_cycle", ack_at(0) - s0, 5);
    check("s6_cyc_cycles", n_cyc_hi, 3);
    check("s6_if_rdata", if_rdata_o, 32'h1234_5678);

    // Reset in the middle of a MEM transaction.
    clear_counts();
    slv_fixed = NEVER; slv_data_rand = 1'b1;
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_sel_i = 4'h3; mem_addr_i = 32'h600; mem_wdata_i = 32'hCAFE_0001;
    repeat (3) cycle();
    rst = 1'b1; mem_req_i = 1'b0;
    cycle();
    rst = 1'b0;
    check("s7_cyc_after_rst", 32'(bus_cyc_o), 32'h0);
    check("s7_mem_rdata_rst", mem_rdata_o, 32'h0);
    check("s7_if_rdata_rst", if_rdata_o, 32'h0);
    repeat (4) cycle();
    check("s7_no_mem_ack", n_mem_acks, 0);

    // Randomized traffic against the model.
    clear_counts();
    slv_fixed = -1;
    auto_mode = 1'b1;
    repeat (3000) cycle();
    auto_mode = 1'b0;
    rst = 1'b0; if_flush_i = 1'b0;
    for (int i = 0; i < 200 && (if_req_i || mem_req_i); i++) cycle();
    check("rand_drained", 32'(if_req_i | mem_req_i), 32'h0);
    check("rand_saw_traffic", 32'(n_if_acks > 20 && n_mem_acks > 20), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
